// File: rtl/core_pkg.sv
// Shared encodings for the multi-cycle core: FSM states, trap causes, access sizes, load funct3.
package core_pkg;

    typedef enum logic [3:0] {
        ST_FETCH      = 4'd0,
        ST_WAIT_FETCH = 4'd1,
        ST_DECODE     = 4'd2,
        ST_EXECUTE    = 4'd3,
        ST_MEM        = 4'd4,
        ST_WAIT_MEM   = 4'd5,
        ST_WRITEBACK  = 4'd6,
        ST_TRAP       = 4'd7,
        ST_HALT       = 4'd8
    } state_t;

    localparam logic [3:0] CAUSE_FETCH_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_FETCH_FAULT    = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT    = 4'd7;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

endpackage

// File: rtl/load_store_align.sv
// load_store_align: misalignment check, store lane replication, load lane select and extension.
// Latency: purely combinational, zero cycles.
// Backpressure: none; results are valid whenever the inputs are.
module load_store_align
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      addr_lsb,
    input  logic [1:0]      size,
    input  logic [XLEN-1:0] store_src,
    input  logic [1:0]      load_lane,
    input  logic [2:0]      load_funct3,
    input  logic [XLEN-1:0] load_raw,
    output logic            misaligned,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        misaligned = 1'b0;
        store_data = store_src;
        case (size)
            SIZE_BYTE: store_data = {(XLEN/8){store_src[7:0]}};
            SIZE_HALF: begin
                store_data = {(XLEN/16){store_src[15:0]}};
                misaligned = addr_lsb[0];
            end
            SIZE_WORD: misaligned = |addr_lsb;
            default:   misaligned = 1'b1;
        endcase
    end

    // Half-word lanes are selected by addr[1] only; aligned halves never straddle.
    assign lane_b = load_raw[{load_lane, 3'b000} +: 8];
    assign lane_h = load_raw[{load_lane[1], 4'b0000} +: 16];

    always_comb begin
        case (load_funct3)
            LD_LB:   load_data = {{(XLEN-8){lane_b[7]}}, lane_b};
            LD_LH:   load_data = {{(XLEN-16){lane_h[15]}}, lane_h};
            LD_LBU:  load_data = {{(XLEN-8){1'b0}}, lane_b};
            LD_LHU:  load_data = {{(XLEN-16){1'b0}}, lane_h};
            LD_LW:   load_data = load_raw;
            default: load_data = load_raw;
        endcase
    end

endmodule

// File: rtl/multicycle_core_ctrl.sv
// multicycle_core_ctrl: RV32I multi-cycle sequencer owning PC, FSM, load/store shaping and traps.
// Latency: 5 cycles plus fetch wait for ALU/branch/jump; loads/stores add MEM and WAIT_MEM.
// Backpressure: mem_req held until mem_ready; waiting MEM_TIMEOUT cycles raises an access fault.
module multicycle_core_ctrl
    import core_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_PC     = 32'h0000_0100,
    parameter int              MEM_TIMEOUT = 255,
    parameter int              CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic [1:0]       mem_size,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic             mem_ready,
    input  logic             mem_err,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic [XLEN-1:0]  instr,
    input  logic             dec_error,
    input  logic             rs1_use_pc,
    input  logic             rs2_use_imm,
    input  logic             mem_to_reg,
    input  logic             branch,
    input  logic             jump,
    input  logic             jal_or_jalr,   // high selects jal, low selects jalr
    input  logic [XLEN-1:0]  dec_imm,
    input  logic [2:0]       dec_load_size,
    input  logic [1:0]       dec_store_size,
    input  logic [XLEN-1:0]  rv1,
    input  logic [XLEN-1:0]  rv2,
    output logic             rf_we,
    output logic [XLEN-1:0]  rf_wdata,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    input  logic [XLEN-1:0]  alu_y,
    input  logic             branch_taken,
    output logic [XLEN-1:0]  pc,
    output logic [3:0]       state,
    output logic [3:0]       trap_cause,
    output logic [XLEN-1:0]  trap_epc,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_d, instr_d, alu_a_d, alu_b_d, mem_addr_d, mem_wdata_d;
    logic [XLEN-1:0]   load_q, load_d, trap_epc_d;
    logic              mem_req_d, mem_we_d, halted_d;
    logic [1:0]        mem_size_d, acc_size;
    logic [3:0]        cause_q, cause_d, trap_cause_d, fault_cause;
    logic [CNT_W-1:0]  retired_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              fault, accepted, timed_out, is_store;
    logic              lsa_misaligned;
    logic [XLEN-1:0]   lsa_store, lsa_load;

    assign state     = state_q;
    assign accepted  = mem_req && mem_ready;
    assign timed_out = (tmo_q == TMO_LAST);
    assign is_store  = !mem_to_reg && (dec_store_size != 2'd0);
    assign acc_size  = mem_to_reg ? dec_load_size[1:0] : (dec_store_size - 2'd1);

    load_store_align #(.XLEN(XLEN)) u_align (
        .addr_lsb    (alu_y[1:0]),
        .size        (acc_size),
        .store_src   (rv2),
        .load_lane   (mem_addr[1:0]),
        .load_funct3 (dec_load_size),
        .load_raw    (load_q),
        .misaligned  (lsa_misaligned),
        .store_data  (lsa_store),
        .load_data   (lsa_load)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_FETCH;
            pc         <= RESET_PC;
            instr      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_size   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            load_q     <= '0;
            cause_q    <= '0;
            trap_cause <= '0;
            trap_epc   <= '0;
            halted     <= 1'b0;
            retired    <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc         <= pc_d;
            instr      <= instr_d;
            alu_a      <= alu_a_d;
            alu_b      <= alu_b_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_size   <= mem_size_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            load_q     <= load_d;
            cause_q    <= cause_d;
            trap_cause <= trap_cause_d;
            trap_epc   <= trap_epc_d;
            halted     <= halted_d;
            retired    <= retired_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc;
        instr_d      = instr;
        alu_a_d      = alu_a;
        alu_b_d      = alu_b;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_size_d   = mem_size;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        load_d       = load_q;
        cause_d      = cause_q;
        trap_cause_d = trap_cause;
        trap_epc_d   = trap_epc;
        halted_d     = halted;
        retired_d    = retired;
        tmo_d        = tmo_q;
        fault        = 1'b0;
        fault_cause  = '0;
        rf_we        = 1'b0;
        rf_wdata     = '0;

        case (state_q)
            ST_FETCH: begin
                if (|pc[1:0]) begin
                    fault       = 1'b1;
                    fault_cause = CAUSE_FETCH_MISALIGN;
                end else begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_size_d  = SIZE_WORD;
                    mem_addr_d  = pc;
                    mem_wdata_d = '0;
                    tmo_d       = '0;
                    state_d     = ST_WAIT_FETCH;
                end
            end
            ST_WAIT_FETCH: begin
                // Ready wins over a timeout landing on the same cycle.
                if (accepted && !mem_err) begin
                    instr_d   = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = ST_DECODE;
                end else if (accepted || timed_out) begin
                    fault       = 1'b1;
                    fault_cause = CAUSE_FETCH_FAULT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_DECODE: begin
                if (dec_error) begin
                    fault       = 1'b1;
                    fault_cause = CAUSE_ILLEGAL;
                end else begin
                    alu_a_d = rs1_use_pc ? pc : rv1;
                    alu_b_d = rs2_use_imm ? dec_imm : rv2;
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                state_d = (mem_to_reg || dec_store_size != 2'd0) ? ST_MEM : ST_WRITEBACK;
            end
            ST_MEM: begin
                if (lsa_misaligned) begin
                    fault       = 1'b1;
                    fault_cause = mem_to_reg ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN;
                end else begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = !mem_to_reg;
                    mem_size_d  = acc_size;
                    mem_addr_d  = alu_y;
                    mem_wdata_d = lsa_store;
                    tmo_d       = '0;
                    state_d     = ST_WAIT_MEM;
                end
            end
            ST_WAIT_MEM: begin
                if (accepted && !mem_err) begin
                    load_d    = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = ST_WRITEBACK;
                end else if (accepted || timed_out) begin
                    fault       = 1'b1;
                    fault_cause = mem_we ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_WRITEBACK: begin
                rf_we = !is_store && !branch;
                if (jump)            rf_wdata = pc + XLEN'(4);
                else if (mem_to_reg) rf_wdata = lsa_load;
                else                 rf_wdata = alu_y;
                if (jump && jal_or_jalr)        pc_d = pc + dec_imm;
                else if (jump)                  pc_d = (rv1 + dec_imm) & {{(XLEN-1){1'b1}}, 1'b0};
                else if (branch && branch_taken) pc_d = pc + dec_imm;
                else                            pc_d = pc + XLEN'(4);
                retired_d = retired + CNT_W'(1);
                state_d   = ST_FETCH;
            end
            ST_TRAP: begin
                trap_epc_d   = pc;
                trap_cause_d = cause_q;
                pc_d         = TRAP_PC;
                state_d      = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase

        // A fetch-side fault inside the trap handler itself cannot recover.
        if (fault) begin
            mem_req_d = 1'b0;
            cause_d   = fault_cause;
            if ((fault_cause == CAUSE_FETCH_MISALIGN || fault_cause == CAUSE_FETCH_FAULT)
                && pc == TRAP_PC) begin
                state_d      = ST_HALT;
                halted_d     = 1'b1;
                trap_cause_d = fault_cause;
                trap_epc_d   = pc;
            end else begin
                state_d = ST_TRAP;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_core_ctrl.sv
// Directed bench for multicycle_core_ctrl: bench acts as memory, decoder, regfile and ALU.
module tb_multicycle_core_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req, mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0, mem_err = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] instr;
    logic        dec_error = 1'b0, rs1_use_pc = 1'b0, rs2_use_imm = 1'b0, mem_to_reg = 1'b0;
    logic        branch = 1'b0, jump = 1'b0, jal_or_jalr = 1'b0;
    logic [31:0] dec_imm = '0;
    logic [2:0]  dec_load_size = '0;
    logic [1:0]  dec_store_size = '0;
    logic [31:0] rv1 = '0, rv2 = '0;
    logic        rf_we;
    logic [31:0] rf_wdata, alu_a, alu_b;
    logic [31:0] alu_y = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] pc;
    logic [3:0]  state, trap_cause;
    logic [31:0] trap_epc;
    logic        halted;
    logic [31:0] retired;

    int vectors = 0;
    int miscompares = 0;

    multicycle_core_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_err(mem_err), .mem_rdata(mem_rdata),
        .instr(instr), .dec_error(dec_error), .rs1_use_pc(rs1_use_pc), .rs2_use_imm(rs2_use_imm),
        .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump), .jal_or_jalr(jal_or_jalr),
        .dec_imm(dec_imm), .dec_load_size(dec_load_size), .dec_store_size(dec_store_size),
        .rv1(rv1), .rv2(rv2), .rf_we(rf_we), .rf_wdata(rf_wdata), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .branch_taken(branch_taken), .pc(pc), .state(state),
        .trap_cause(trap_cause), .trap_epc(trap_epc), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_dec(input logic mtr, input logic [2:0] lsz, input logic [1:0] ssz,
                           input logic br, input logic jmp, input logic jsel,
                           input logic r1pc, input logic r2imm, input logic [31:0] imm,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] y,
                           input logic taken);
        mem_to_reg = mtr; dec_load_size = lsz; dec_store_size = ssz;
        branch = br; jump = jmp; jal_or_jalr = jsel;
        rs1_use_pc = r1pc; rs2_use_imm = r2imm; dec_imm = imm;
        rv1 = a; rv2 = b; alu_y = y; branch_taken = taken;
    endtask

    // Waits (bounded) for a request, stalls dly cycles, then completes it for one cycle.
    task automatic mem_respond(input int dly, input logic [31:0] rd, input logic err);
        int n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", {31'd0, mem_req}, 32'd1);
        repeat (dly) tick();
        mem_ready = 1'b1; mem_rdata = rd; mem_err = err;
        tick();
        mem_ready = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    endtask

    // Called with the FSM in FETCH; returns with it in DECODE.
    task automatic fetch(input logic [31:0] ins, input int dly);
        tick();
        mem_respond(dly, ins, 1'b0);
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        tick(); tick();
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        rst = 1'b1;

        // addi x1,x0,5 with ready after 3 cycles
        set_dec(0, 3'b000, 2'd0, 0, 0, 0, 0, 1, 32'd5, 32'd0, 32'd0, 32'd5, 0);
        tick();
        chk("fetch_state", {28'd0, state}, 32'd1);
        chk("fetch_req", {31'd0, mem_req}, 32'd1);
        chk("fetch_addr", mem_addr, 32'h0);
        chk("fetch_size", {30'd0, mem_size}, 32'd2);
        chk("fetch_we", {31'd0, mem_we}, 32'd0);
        mem_respond(3, 32'h0050_0093, 1'b0);
        chk("dec_state", {28'd0, state}, 32'd2);
        chk("dec_instr", instr, 32'h0050_0093);
        chk("dec_req_drop", {31'd0, mem_req}, 32'd0);
        tick();
        chk("ex_alu_a", alu_a, 32'd0);
        chk("ex_alu_b", alu_b, 32'd5);
        tick();
        chk("addi_rf_we", {31'd0, rf_we}, 32'd1);
        chk("addi_wdata", rf_wdata, 32'd5);
        tick();
        chk("addi_pc", pc, 32'h4);
        chk("addi_retired", retired, 32'd1);
        chk("addi_rf_we_off", {31'd0, rf_we}, 32'd0);

        // sh to 0x102, rv2=0x1234ABCD
        set_dec(0, 3'b000, 2'd2, 0, 0, 0, 0, 1, 32'h102, 32'd0, 32'h1234_ABCD, 32'h102, 0);
        fetch(32'h1020_1123, 1);
        tick(); tick(); tick();
        chk("sh_state", {28'd0, state}, 32'd5);
        chk("sh_we", {31'd0, mem_we}, 32'd1);
        chk("sh_size", {30'd0, mem_size}, 32'd1);
        chk("sh_addr", mem_addr, 32'h102);
        chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        mem_respond(0, 32'h0, 1'b0);
        chk("sh_no_rf_we", {31'd0, rf_we}, 32'd0);
        tick();
        chk("sh_pc", pc, 32'h8);

        // lbu at 0x103, rdata=0x80FF0000
        set_dec(1, 3'b100, 2'd0, 0, 0, 0, 0, 1, 32'h103, 32'd0, 32'd0, 32'h103, 0);
        fetch(32'h1030_4083, 0);
        tick(); tick(); tick();
        chk("lbu_we", {31'd0, mem_we}, 32'd0);
        chk("lbu_size", {30'd0, mem_size}, 32'd0);
        mem_respond(2, 32'h80FF_0000, 1'b0);
        chk("lbu_rf_we", {31'd0, rf_we}, 32'd1);
        chk("lbu_wdata", rf_wdata, 32'h0000_0080);
        tick();

        // lb, same address and data
        set_dec(1, 3'b000, 2'd0, 0, 0, 0, 0, 1, 32'h103, 32'd0, 32'd0, 32'h103, 0);
        fetch(32'h1030_0083, 0);
        tick(); tick(); tick();
        mem_respond(0, 32'h80FF_0000, 1'b0);
        chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
        tick();
        chk("lb_pc", pc, 32'h10);
        chk("lb_retired", retired, 32'd4);

        // lw to 0x2: misaligned load trap
        set_dec(1, 3'b010, 2'd0, 0, 0, 0, 0, 1, 32'h2, 32'd0, 32'd0, 32'h2, 0);
        fetch(32'h0020_2083, 0);
        tick(); tick(); tick();
        chk("lwmis_state", {28'd0, state}, 32'd7);
        chk("lwmis_req", {31'd0, mem_req}, 32'd0);
        chk("lwmis_rf_we", {31'd0, rf_we}, 32'd0);
        tick();
        chk("lwmis_cause", {28'd0, trap_cause}, 32'd4);
        chk("lwmis_epc", trap_epc, 32'h10);
        chk("lwmis_pc", pc, 32'h100);
        chk("lwmis_retired", retired, 32'd4);

        // jalr at 0x100, rv1=0x21, imm=0
        set_dec(0, 3'b000, 2'd0, 0, 1, 0, 0, 1, 32'h0, 32'h21, 32'd0, 32'h21, 0);
        fetch(32'h0000_80E7, 0);
        tick(); tick();
        chk("jalr_rf_we", {31'd0, rf_we}, 32'd1);
        chk("jalr_link", rf_wdata, 32'h104);
        tick();
        chk("jalr_pc", pc, 32'h20);

        // jal at 0x20, imm=0x20; ready lands on the final timeout cycle
        set_dec(0, 3'b000, 2'd0, 0, 1, 1, 1, 1, 32'h20, 32'd0, 32'd0, 32'h40, 0);
        fetch(32'h0200_00EF, 254);
        chk("edge_ready_state", {28'd0, state}, 32'd2);
        tick(); tick();
        chk("jal_link", rf_wdata, 32'h24);
        tick();
        chk("jal_pc", pc, 32'h40);

        // beq taken at 0x40, imm=-8
        set_dec(0, 3'b000, 2'd0, 1, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'd7, 32'd7, 32'd0, 1);
        fetch(32'hFE20_8CE3, 0);
        tick(); tick();
        chk("beq_rf_we", {31'd0, rf_we}, 32'd0);
        tick();
        chk("beq_pc", pc, 32'h38);
        chk("beq_retired", retired, 32'd7);

        // fetch timeout at 0x38
        tick();
        chk("tmo_addr", mem_addr, 32'h38);
        repeat (255) tick();
        chk("tmo_state", {28'd0, state}, 32'd7);
        chk("tmo_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("tmo_cause", {28'd0, trap_cause}, 32'd1);
        chk("tmo_epc", trap_epc, 32'h38);
        chk("tmo_pc", pc, 32'h100);

        // same timeout inside the trap handler: double fault
        tick();
        repeat (255) tick();
        chk("dbl_state", {28'd0, state}, 32'd8);
        chk("dbl_halted", {31'd0, halted}, 32'd1);
        repeat (3) tick();
        chk("halt_stays", {28'd0, state}, 32'd8);
        chk("halt_no_req", {31'd0, mem_req}, 32'd0);

        // reset leaves HALT
        rst = 1'b0;
        tick();
        chk("rst2_state", {28'd0, state}, 32'd0);
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        chk("rst2_retired", retired, 32'd0);
        rst = 1'b1;

        set_dec(0, 3'b000, 2'd0, 0, 0, 0, 0, 1, 32'd5, 32'd0, 32'd0, 32'd5, 0);
        fetch(32'h0050_0093, 0);
        tick(); tick(); tick();
        chk("addi2_retired", retired, 32'd1);

        // load bus error at pc 4
        set_dec(1, 3'b010, 2'd0, 0, 0, 0, 0, 1, 32'h200, 32'd0, 32'd0, 32'h200, 0);
        fetch(32'h2000_2083, 0);
        tick(); tick(); tick();
        mem_respond(1, 32'hDEAD_BEEF, 1'b1);
        chk("lderr_state", {28'd0, state}, 32'd7);
        tick();
        chk("lderr_cause", {28'd0, trap_cause}, 32'd5);
        chk("lderr_epc", trap_epc, 32'h4);
        chk("lderr_pc", pc, 32'h100);

        // reset asserted while a load waits in WAIT_MEM
        set_dec(1, 3'b010, 2'd0, 0, 0, 0, 0, 1, 32'h204, 32'd0, 32'd0, 32'h204, 0);
        fetch(32'h2040_2083, 0);
        tick(); tick(); tick(); tick();
        chk("wm_state", {28'd0, state}, 32'd5);
        chk("wm_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b0;
        tick();
        chk("rst3_req", {31'd0, mem_req}, 32'd0);
        chk("rst3_pc", pc, 32'h0);
        chk("rst3_state", {28'd0, state}, 32'd0);
        chk("rst3_retired", retired, 32'd0);
        chk("rst3_cause", {28'd0, trap_cause}, 32'd0);
        chk("rst3_epc", trap_epc, 32'h0);
        rst = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
